// File: rtl/otter_pkg.sv
// ----------------------------------------------------------------------------
// otter_pkg
// Shared types and constants for the OTTER multicycle control unit.
//   opcode_t    : the ten RV32 base opcodes the control unit recognises
//   cu_state_t  : control FSM states
//   cu_en_t     : bundle of every enable/strobe the control unit drives
//   FUNC3_*     : func3 values that split the SYSTEM opcode
// ----------------------------------------------------------------------------
package otter_pkg;

  // Width of the init-cycle counter; wide enough for INIT_CYCLES up to 15
  localparam int INIT_CNT_W = 4;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_BRANCH = 7'b1100011,
    OPC_STORE  = 7'b0100011,
    OPC_LOAD   = 7'b0000011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } cu_state_t;

  // SYSTEM opcode sub-decodes: csrrw and the privileged group (mret)
  localparam logic [2:0] FUNC3_CSRRW = 3'b001;
  localparam logic [2:0] FUNC3_PRIV  = 3'b000;

  typedef struct packed {
    logic pcLd;
    logic regWe;
    logic memWe2;
    logic memRden1;
    logic memRden2;
    logic csrWe;
    logic intTaken;
    logic mretExec;
    logic rstOut;
    logic illegal;
  } cu_en_t;

endpackage

// File: rtl/otter_cu_dcdr_en.sv
// ----------------------------------------------------------------------------
// otter_cu_dcdr_en
// Purely combinational enable decoder for the OTTER control unit. Given the
// current FSM state and the fetched instruction's opcode/func3 it produces
// the full enable vector for that cycle.
// Ports:
//   i_state  : current control FSM state
//   i_opcode : instruction bits [6:0]
//   i_func3  : instruction bits [14:12]
//   o_en     : enable vector (PC load, RF/mem/CSR writes, reads, strobes)
// ----------------------------------------------------------------------------
module otter_cu_dcdr_en
  import otter_pkg::*;
(
  input  cu_state_t  i_state,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_func3,
  output cu_en_t     o_en
);

  // Every enable defaults low so each state only names what it turns on.
  // In EXEC the PC advances for everything except a load, which finishes
  // its retirement in WB once the data memory has returned the value.
  always_comb begin
    o_en = '0;
    unique case (i_state)
      ST_INIT: begin
        o_en.rstOut = 1'b1;
      end
      ST_FETCH: begin
        o_en.memRden1 = 1'b1;
      end
      ST_EXEC: begin
        o_en.pcLd = 1'b1;
        case (i_opcode)
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
            o_en.regWe = 1'b1;
          end
          OPC_BRANCH: begin
          end
          OPC_STORE: begin
            o_en.memWe2 = 1'b1;
          end
          OPC_LOAD: begin
            o_en.memRden2 = 1'b1;
            o_en.pcLd     = 1'b0;
          end
          OPC_SYSTEM: begin
            if (i_func3 == FUNC3_CSRRW) begin
              o_en.csrWe = 1'b1;
              o_en.regWe = 1'b1;
            end else if (i_func3 == FUNC3_PRIV) begin
              o_en.mretExec = 1'b1;
            end else begin
              o_en.illegal = 1'b1;
            end
          end
          default: begin
            o_en.illegal = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        o_en.regWe = 1'b1;
        o_en.pcLd  = 1'b1;
      end
      ST_INTR: begin
        o_en.intTaken = 1'b1;
        o_en.pcLd     = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/otter_cu_fsm.sv
// ----------------------------------------------------------------------------
// otter_cu_fsm
// Multicycle control state machine for the OTTER core. Sequences init,
// fetch, execute, load writeback and interrupt entry, and latches a
// level-sensitive external interrupt until it is serviced.
// Ports:
//   CLK        : system clock, rising edge
//   RST_N      : synchronous active-low reset
//   OPCODE     : instruction bits [6:0]
//   FUNC3      : instruction bits [14:12]
//   INTR       : external interrupt request (level)
//   MIE        : machine interrupt enable from the CSR file
//   PC_LD      : PC load enable (one pulse per retired instruction)
//   REG_WE     : register-file write enable
//   MEM_WE2    : data memory write enable
//   MEM_RDEN1  : instruction memory read enable
//   MEM_RDEN2  : data memory read enable
//   CSR_WE     : CSR write enable
//   INT_TAKEN  : interrupt entry pulse
//   MRET_EXEC  : mret executing
//   RST_OUT    : reset to PC and register file
//   ILLEGAL    : unrecognised-instruction pulse
// ----------------------------------------------------------------------------
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int OPC_W       = 7,
  parameter int INIT_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [OPC_W-1:0] OPCODE,
  input  logic [2:0]       FUNC3,
  input  logic             INTR,
  input  logic             MIE,
  output logic             PC_LD,
  output logic             REG_WE,
  output logic             MEM_WE2,
  output logic             MEM_RDEN1,
  output logic             MEM_RDEN2,
  output logic             CSR_WE,
  output logic             INT_TAKEN,
  output logic             MRET_EXEC,
  output logic             RST_OUT,
  output logic             ILLEGAL
);

  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);

  cu_state_t             r_state;
  cu_state_t             w_nextState;
  logic [INIT_CNT_W-1:0] r_initCnt;
  logic [INIT_CNT_W-1:0] w_nextInitCnt;
  logic                  r_intPend;
  logic                  w_nextIntPend;
  cu_en_t                w_en;
  cu_en_t                w_out;

  otter_cu_dcdr_en u_dcdr (
    .i_state  (r_state),
    .i_opcode (OPCODE),
    .i_func3  (FUNC3),
    .o_en     (w_en)
  );

  // State, init counter and pending-interrupt latch all return to their
  // power-on values on any edge where reset is held low, from any state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= ST_INIT;
      r_initCnt <= '0;
      r_intPend <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_initCnt <= w_nextInitCnt;
      r_intPend <= w_nextIntPend;
    end
  end

  // Next-state logic. The pending latch is cleared on the edge that leaves
  // ST_INTR and ignores requests while in it, so a request held high across
  // entry is not serviced twice for the same assertion window. Interrupts are
  // only considered at instruction boundaries, which keeps a load's EXEC and
  // WB back to back and lets an mret finish before the trap is entered.
  always_comb begin
    w_nextState   = r_state;
    w_nextInitCnt = r_initCnt;
    w_nextIntPend = r_intPend;

    if (r_state == ST_INTR) begin
      w_nextIntPend = 1'b0;
    end else if (INTR && MIE) begin
      w_nextIntPend = 1'b1;
    end

    unique case (r_state)
      ST_INIT: begin
        if (r_initCnt == INIT_LAST) begin
          w_nextState   = ST_FETCH;
          w_nextInitCnt = '0;
        end else begin
          w_nextInitCnt = r_initCnt + 1'b1;
        end
      end
      ST_FETCH: begin
        w_nextState = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_en.memRden2) begin
          w_nextState = ST_WB;
        end else begin
          w_nextState = r_intPend ? ST_INTR : ST_FETCH;
        end
      end
      ST_WB: begin
        w_nextState = r_intPend ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        w_nextState = ST_FETCH;
      end
      default: begin
        w_nextState = ST_INIT;
      end
    endcase
  end

  // Reset overrides the decoder combinationally so that no write strobe can
  // escape in the very cycle reset is asserted, whatever state we were in.
  always_comb begin
    w_out = w_en;
    if (!RST_N) begin
      w_out        = '0;
      w_out.rstOut = 1'b1;
    end
  end

  assign PC_LD     = w_out.pcLd;
  assign REG_WE    = w_out.regWe;
  assign MEM_WE2   = w_out.memWe2;
  assign MEM_RDEN1 = w_out.memRden1;
  assign MEM_RDEN2 = w_out.memRden2;
  assign CSR_WE    = w_out.csrWe;
  assign INT_TAKEN = w_out.intTaken;
  assign MRET_EXEC = w_out.mretExec;
  assign RST_OUT   = w_out.rstOut;
  assign ILLEGAL   = w_out.illegal;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// ----------------------------------------------------------------------------
// tb_otter_cu_fsm
// Self-checking bench for otter_cu_fsm: directed scenarios followed by random
// opcode/interrupt/reset traffic, compared cycle by cycle with a behavioural
// model of the control unit's instruction sequencing.
// ----------------------------------------------------------------------------
module tb_otter_cu_fsm;

  localparam int INIT_CYCLES = 1;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OPALU  = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [6:0] OPCODE = '0;
  logic [2:0] FUNC3 = '0;
  logic       INTR = 1'b0;
  logic       MIE = 1'b0;
  logic PC_LD, REG_WE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE;
  logic INT_TAKEN, MRET_EXEC, RST_OUT, ILLEGAL;

  otter_cu_fsm #(.OPC_W(7), .INIT_CYCLES(INIT_CYCLES)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .OPCODE    (OPCODE),
    .FUNC3     (FUNC3),
    .INTR      (INTR),
    .MIE       (MIE),
    .PC_LD     (PC_LD),
    .REG_WE    (REG_WE),
    .MEM_WE2   (MEM_WE2),
    .MEM_RDEN1 (MEM_RDEN1),
    .MEM_RDEN2 (MEM_RDEN2),
    .CSR_WE    (CSR_WE),
    .INT_TAKEN (INT_TAKEN),
    .MRET_EXEC (MRET_EXEC),
    .RST_OUT   (RST_OUT),
    .ILLEGAL   (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Model: which kind of cycle the machine is in, how many boot cycles
  // remain, and whether an interrupt is waiting for an instruction boundary.
  typedef enum int {K_BOOT, K_FETCH, K_EXEC, K_WB, K_TRAP} kind_t;
  kind_t mKind = K_BOOT;
  int    mBootLeft = INIT_CYCLES;
  bit    mPend = 1'b0;
  int    mRetired = 0;
  int    dRetired = 0;
  int    seenTaken = 0;
  int    seenPcLd = 0;

  logic [6:0] opcList [10] = '{LUI, AUIPC, JAL, JALR, OPIMM, OPALU,
                               BRANCH, STORE, LOAD, SYSTEM};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Bit order: PC_LD REG_WE MEM_WE2 MEM_RDEN1 MEM_RDEN2 CSR_WE
  //            INT_TAKEN MRET_EXEC RST_OUT ILLEGAL
  function automatic logic [9:0] expectedOutputs(kind_t k, bit rstN,
                                                 logic [6:0] opc, logic [2:0] f3);
    bit pcLd, regWe, memWe, rd1, rd2, csrWe, intT, mret, rstO, ill;
    {pcLd, regWe, memWe, rd1, rd2, csrWe, intT, mret, rstO, ill} = '0;
    if (!rstN) begin
      rstO = 1'b1;
    end else if (k == K_BOOT) begin
      rstO = 1'b1;
    end else if (k == K_FETCH) begin
      rd1 = 1'b1;
    end else if (k == K_WB) begin
      regWe = 1'b1;
      pcLd  = 1'b1;
    end else if (k == K_TRAP) begin
      intT = 1'b1;
      pcLd = 1'b1;
    end else begin
      pcLd = 1'b1;
      if (opc inside {LUI, AUIPC, JAL, JALR, OPIMM, OPALU}) regWe = 1'b1;
      else if (opc == BRANCH) ;
      else if (opc == STORE) memWe = 1'b1;
      else if (opc == LOAD) begin rd2 = 1'b1; pcLd = 1'b0; end
      else if (opc == SYSTEM && f3 == 3'b001) begin csrWe = 1'b1; regWe = 1'b1; end
      else if (opc == SYSTEM && f3 == 3'b000) mret = 1'b1;
      else ill = 1'b1;
    end
    return {pcLd, regWe, memWe, rd1, rd2, csrWe, intT, mret, rstO, ill};
  endfunction

  task automatic advanceModel(bit rstN, logic [6:0] opc, bit intr, bit mie);
    bit nextPend;
    if (!rstN) begin
      mKind = K_BOOT;
      mBootLeft = INIT_CYCLES;
      mPend = 1'b0;
      return;
    end
    nextPend = mPend;
    if (mKind == K_TRAP) nextPend = 1'b0;
    else if (intr && mie) nextPend = 1'b1;
    case (mKind)
      K_BOOT: begin
        mBootLeft--;
        if (mBootLeft == 0) mKind = K_FETCH;
      end
      K_FETCH: mKind = K_EXEC;
      K_EXEC:  mKind = (opc == LOAD) ? K_WB : (mPend ? K_TRAP : K_FETCH);
      K_WB:    mKind = mPend ? K_TRAP : K_FETCH;
      default: mKind = K_FETCH;
    endcase
    mPend = nextPend;
  endtask

  // One clock: drive inputs after the falling edge, check the settled
  // outputs against the model, then step the model across the rising edge.
  task automatic applyStimulus(input bit rstN, input logic [6:0] opc,
                               input logic [2:0] f3, input bit intr,
                               input bit mie, input string tag);
    logic [9:0] exp;
    logic [9:0] obs;
    @(negedge CLK);
    RST_N = rstN; OPCODE = opc; FUNC3 = f3; INTR = intr; MIE = mie;
    #1;
    exp = expectedOutputs(mKind, rstN, opc, f3);
    obs = {PC_LD, REG_WE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE,
           INT_TAKEN, MRET_EXEC, RST_OUT, ILLEGAL};
    checkOutput(tag, 32'(obs), 32'(exp));
    if (PC_LD) begin dRetired++; seenPcLd++; end
    if (INT_TAKEN) seenTaken++;
    if (exp[9]) mRetired++;
    @(posedge CLK);
    advanceModel(rstN, opc, intr, mie);
  endtask

  // Run ALU ops until the model reaches a fetch cycle; bounded.
  task automatic syncToFetch();
    int n = 0;
    while (mKind != K_FETCH && n < 10) begin
      applyStimulus(1'b1, OPALU, 3'b000, 1'b0, 1'b0, "sync");
      n++;
    end
    if (mKind != K_FETCH) checkOutput("syncFetch", 32'(n), 32'(0));
  endtask

  initial begin
    bit pulsed;
    logic [6:0] opc;

    // Reset held three cycles, then boot and first fetch
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 7'($urandom), 3'($urandom), 1'b1, 1'b1, "reset");
    applyStimulus(1'b1, OPALU, 3'b000, 1'b0, 1'b0, "init");
    applyStimulus(1'b1, OPALU, 3'b000, 1'b0, 1'b0, "firstFetch");
    applyStimulus(1'b1, OPALU, 3'b000, 1'b0, 1'b0, "firstExec");

    // ALU ops: one retirement every two cycles
    syncToFetch();
    seenPcLd = 0;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, OPALU, 3'b000, 1'b0, 1'b0, "aluOp");
    checkOutput("aluPeriod", 32'(seenPcLd), 32'd3);

    // Loads: one retirement every three cycles
    syncToFetch();
    seenPcLd = 0;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, LOAD, 3'b010, 1'b0, 1'b0, "loadOp");
    checkOutput("loadPeriod", 32'(seenPcLd), 32'd2);

    // One-cycle interrupt pulse in the fetch of a load: EXEC, WB, INTR, FETCH
    syncToFetch();
    seenTaken = 0;
    pulsed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, LOAD, 3'b010, !pulsed, 1'b1, "ldIntr");
      pulsed = 1'b1;
      if (i == 3) checkOutput("trapAfterWb", 32'(seenTaken), 32'd1);
    end
    checkOutput("ldIntrOnce", 32'(seenTaken), 32'd1);

    // Masked interrupt held high: no trap entry
    seenTaken = 0;
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, opcList[$urandom_range(0, 6)], 3'b000, 1'b1, 1'b0, "masked");
    checkOutput("maskedNoTrap", 32'(seenTaken), 32'd0);

    // mret, illegal system func3, illegal opcode
    syncToFetch();
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, SYSTEM, 3'b000, 1'b0, 1'b0, "mret");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, SYSTEM, 3'b001, 1'b0, 1'b0, "csrrw");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, SYSTEM, 3'b101, 1'b0, 1'b0, "sysIll");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0, "illegal");

    // mret with a pending interrupt: mret retires, then the trap
    syncToFetch();
    seenTaken = 0;
    applyStimulus(1'b1, SYSTEM, 3'b000, 1'b1, 1'b1, "mretIntrF");
    applyStimulus(1'b1, SYSTEM, 3'b000, 1'b0, 1'b1, "mretIntrE");
    applyStimulus(1'b1, OPALU, 3'b000, 1'b0, 1'b1, "mretIntrT");
    checkOutput("mretThenTrap", 32'(seenTaken), 32'd1);

    // Reset during a store's EXEC with an interrupt pending
    syncToFetch();
    applyStimulus(1'b1, STORE, 3'b010, 1'b1, 1'b1, "stFetch");
    applyStimulus(1'b0, STORE, 3'b010, 1'b0, 1'b1, "stReset");
    seenTaken = 0;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, OPALU, 3'b000, 1'b0, 1'b1, "postReset");
    checkOutput("pendCleared", 32'(seenTaken), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) opc = 7'($urandom);
      else opc = opcList[$urandom_range(0, 9)];
      applyStimulus($urandom_range(0, 299) != 0, opc, 3'($urandom_range(0, 3)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, "random");
    end
    checkOutput("retireCount", 32'(dRetired), 32'(mRetired));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
